// File: rtl/falafel_pkg.sv
// Shared falafel memory-interface types: request opcode and request payload.
package falafel_pkg;

  localparam int unsigned DATA_W = 64;

  typedef enum logic [1:0] {
    MEM_RD  = 2'd0,
    MEM_WR  = 2'd1,
    MEM_CAS = 2'd2
  } mem_op_e;

  typedef struct packed {
    mem_op_e           op;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp;
  } mem_req_t;

  // is_cas is only honoured together with is_write.
  function automatic mem_op_e decode_op(input logic is_write, input logic is_cas);
    if (!is_write) return MEM_RD;
    return is_cas ? MEM_CAS : MEM_WR;
  endfunction

endpackage

// File: rtl/falafel_mem_bridge.sv
// Single-outstanding memory bridge: executes read / write / CAS requests against
// a 1-cycle-latency single-port SRAM and returns exactly one response each.
module falafel_mem_bridge
  import falafel_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  localparam int unsigned ADDR_W = $clog2(MEM_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_req_val_i,
  output logic              mem_req_rdy_o,
  input  logic              mem_req_is_write_i,
  input  logic              mem_req_is_cas_i,
  input  logic [DATA_W-1:0] mem_req_addr_i,
  input  logic [DATA_W-1:0] mem_req_data_i,
  input  logic [DATA_W-1:0] mem_req_cas_exp_i,
  output logic              mem_rsp_val_o,
  input  logic              mem_rsp_rdy_i,
  output logic [DATA_W-1:0] mem_rsp_data_o,
  output logic              sram_en_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  input  logic [DATA_W-1:0] sram_rdata_i,
  output logic              err_o,
  output logic [15:0]       cas_fail_cnt_o
);

  localparam int unsigned BYTE_OFF = $clog2(DATA_W / 8);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    CMP  = 3'd3,
    RSP  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  mem_op_e           op_q, op_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic              bad_q, bad_d;
  logic [DATA_W-1:0] rsp_q, rsp_d;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;

  mem_req_t req_in;
  logic     req_bad;

  assign req_in = '{op:   decode_op(mem_req_is_write_i, mem_req_is_cas_i),
                    addr: mem_req_addr_i,
                    data: mem_req_data_i,
                    exp:  mem_req_cas_exp_i};

  // Out-of-range word index or a byte offset inside a word.
  assign req_bad = ((req_in.addr >> BYTE_OFF) >= DATA_W'(MEM_WORDS)) ||
                   (req_in.addr[BYTE_OFF-1:0] != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= MEM_RD;
      waddr_q <= '0;
      data_q  <= '0;
      exp_q   <= '0;
      bad_q   <= 1'b0;
      rsp_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      exp_q   <= exp_d;
      bad_q   <= bad_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    waddr_d       = waddr_q;
    data_d        = data_q;
    exp_d         = exp_q;
    bad_d         = bad_q;
    rsp_d         = rsp_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    mem_req_rdy_o = 1'b0;
    mem_rsp_val_o = 1'b0;
    sram_en_o     = 1'b0;
    sram_we_o     = 1'b0;
    sram_addr_o   = '0;
    sram_wdata_o  = '0;

    case (state_q)
      IDLE: begin
        mem_req_rdy_o = 1'b1;
        if (mem_req_val_i) begin
          op_d    = req_in.op;
          waddr_d = ADDR_W'(req_in.addr >> BYTE_OFF);
          data_d  = req_in.data;
          exp_d   = req_in.exp;
          bad_d   = req_bad;
          if (req_bad) err_d = 1'b1;
          state_d = (req_in.op == MEM_WR) ? WR : RD;
        end
      end
      RD: begin
        if (!bad_q) begin
          sram_en_o   = 1'b1;
          sram_addr_o = waddr_q;
        end
        state_d = CMP;
      end
      WR: begin
        if (!bad_q) begin
          sram_en_o    = 1'b1;
          sram_we_o    = 1'b1;
          sram_addr_o  = waddr_q;
          sram_wdata_o = data_q;
        end
        rsp_d   = '0;
        state_d = RSP;
      end
      CMP: begin
        // Read data lands this cycle; a matching CAS writes back in the same cycle.
        rsp_d = bad_q ? '0 : sram_rdata_i;
        if (!bad_q && op_q == MEM_CAS) begin
          if (sram_rdata_i == exp_q) begin
            sram_en_o    = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = waddr_q;
            sram_wdata_o = data_q;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        state_d = RSP;
      end
      RSP: begin
        mem_rsp_val_o = 1'b1;
        if (mem_rsp_rdy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_rsp_data_o = rsp_q;
  assign err_o          = err_q;
  assign cas_fail_cnt_o = cnt_q;

endmodule

// File: tb/tb_falafel_mem_bridge.sv
// Bench for falafel_mem_bridge: behavioural SRAM, word-array reference model,
// directed scenarios followed by randomized traffic.
module tb_falafel_mem_bridge;
  import falafel_pkg::*;

  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned ADDR_W    = $clog2(MEM_WORDS);

  logic              clk = 1'b0;
  logic              rst;
  logic              req_val, req_rdy, is_write, is_cas;
  logic [DATA_W-1:0] req_addr, req_data, req_exp;
  logic              rsp_val, rsp_rdy;
  logic [DATA_W-1:0] rsp_data;
  logic              sram_en, sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata, sram_rdata;
  logic              err;
  logic [15:0]       cas_fail_cnt;

  int errors = 0;
  int checks = 0;

  falafel_mem_bridge #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .mem_req_val_i      (req_val),
    .mem_req_rdy_o      (req_rdy),
    .mem_req_is_write_i (is_write),
    .mem_req_is_cas_i   (is_cas),
    .mem_req_addr_i     (req_addr),
    .mem_req_data_i     (req_data),
    .mem_req_cas_exp_i  (req_exp),
    .mem_rsp_val_o      (rsp_val),
    .mem_rsp_rdy_i      (rsp_rdy),
    .mem_rsp_data_o     (rsp_data),
    .sram_en_o          (sram_en),
    .sram_we_o          (sram_we),
    .sram_addr_o        (sram_addr),
    .sram_wdata_o       (sram_wdata),
    .sram_rdata_i       (sram_rdata),
    .err_o              (err),
    .cas_fail_cnt_o     (cas_fail_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM with 1-cycle read latency.
  logic [DATA_W-1:0] sram_mem [MEM_WORDS];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  // Activity monitors.
  int en_cnt = 0;
  int wr_cnt = 0;
  int idle_viol = 0;
  always @(posedge clk) begin
    if (sram_en) en_cnt++;
    if (sram_en && sram_we) wr_cnt++;
  end
  always @(negedge clk) begin
    if (!sram_en && (sram_we || sram_addr != '0 || sram_wdata != '0)) idle_viol++;
  end

  // Reference model: plain word array plus sticky error and fail counter.
  logic [DATA_W-1:0] ref_mem [MEM_WORDS];
  logic              ref_err;
  logic [15:0]       ref_cnt;

  function automatic logic ref_bad(input logic [DATA_W-1:0] addr);
    logic [DATA_W-1:0] w;
    w = addr >> 3;
    return (w >= 64'(MEM_WORDS)) || (addr[2:0] != 3'd0);
  endfunction

  function automatic logic [DATA_W-1:0] ref_apply(input mem_op_e op, input logic [DATA_W-1:0] addr,
                                                  input logic [DATA_W-1:0] data,
                                                  input logic [DATA_W-1:0] cexp);
    logic [DATA_W-1:0] old;
    int idx;
    if (ref_bad(addr)) begin
      ref_err = 1'b1;
      return '0;
    end
    idx = int'(addr >> 3);
    old = ref_mem[idx];
    case (op)
      MEM_RD: return old;
      MEM_WR: begin
        ref_mem[idx] = data;
        return '0;
      end
      default: begin
        if (old == cexp) ref_mem[idx] = data;
        else if (ref_cnt != 16'hFFFF) ref_cnt = ref_cnt + 16'd1;
        return old;
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  logic              s_en, s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;

  task automatic drive_req(input mem_op_e op, input logic [DATA_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] cexp);
    req_val  = 1'b1;
    is_write = (op != MEM_RD);
    is_cas   = (op == MEM_CAS);
    req_addr = addr;
    req_data = data;
    req_exp  = cexp;
  endtask

  // Issue one request, then check latency, response and SRAM activity against the model.
  task automatic do_req(input mem_op_e op, input logic [DATA_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] cexp,
                        output logic [DATA_W-1:0] rsp);
    logic [DATA_W-1:0] exp_rsp;
    logic bad;
    int exp_lat, lat, n, en0;
    bad     = ref_bad(addr);
    exp_rsp = ref_apply(op, addr, data, cexp);
    exp_lat = (op == MEM_WR) ? 2 : 3;
    n = 0;
    @(negedge clk);
    while (!req_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_rdy_idle", 64'(req_rdy), 64'd1);
    en0 = en_cnt;
    drive_req(op, addr, data, cexp);
    @(negedge clk);
    req_val = 1'b0;
    s_en = sram_en; s_we = sram_we; s_addr = sram_addr; s_wdata = sram_wdata;
    lat = 1;
    while (!rsp_val && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("rsp_data", rsp_data, exp_rsp);
    rsp = rsp_data;
    if (bad) begin
      chk("bad_no_sram_en", 64'(en_cnt - en0), 64'd0);
    end else begin
      chk("sram_en_first", 64'(s_en), 64'd1);
      chk("sram_we_first", 64'(s_we), 64'(op == MEM_WR));
      chk("sram_addr", 64'(s_addr), addr >> 3);
      if (op == MEM_WR) chk("sram_wdata", s_wdata, data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] r, held;
    int n, w0, lat;
    for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = '0;
    ref_err = 1'b0;
    ref_cnt = '0;
    rst = 1'b1; rsp_rdy = 1'b1;
    req_val = 1'b0; is_write = 1'b0; is_cas = 1'b0;
    req_addr = '0; req_data = '0; req_exp = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_rdy", 64'(req_rdy), 64'd1);
    chk("rst_rsp_val", 64'(rsp_val), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_sram_en", 64'(sram_en), 64'd0);
    chk("rst_sram_we", 64'(sram_we), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_cas_cnt", 64'(cas_fail_cnt), 64'd0);
    rst = 1'b0;

    // 1: write then read word 8
    do_req(MEM_WR, 64'h40, 64'hDEAD_BEEF, 64'd0, r);
    chk("t1_wr_rsp", r, 64'd0);
    chk("t1_wr_addr8", 64'(s_addr), 64'd8);
    do_req(MEM_RD, 64'h40, 64'd0, 64'd0, r);
    chk("t1_rd_rsp", r, 64'hDEAD_BEEF);

    // 2: successful CAS
    do_req(MEM_WR, 64'h40, 64'd5, 64'd0, r);
    do_req(MEM_CAS, 64'h40, 64'd9, 64'd5, r);
    chk("t2_cas_old", r, 64'd5);
    do_req(MEM_RD, 64'h40, 64'd0, 64'd0, r);
    chk("t2_rd_new", r, 64'd9);
    chk("t2_cnt", 64'(cas_fail_cnt), 64'd0);

    // 3: failing CAS
    do_req(MEM_CAS, 64'h40, 64'h11, 64'd7, r);
    chk("t3_cas_old", r, 64'd9);
    do_req(MEM_RD, 64'h40, 64'd0, 64'd0, r);
    chk("t3_rd_keep", r, 64'd9);
    chk("t3_cnt", 64'(cas_fail_cnt), 64'd1);

    // 4: response stall with a second request waiting
    rsp_rdy = 1'b0;
    r = ref_apply(MEM_RD, 64'h40, 64'd0, 64'd0);
    @(negedge clk);
    drive_req(MEM_RD, 64'h40, 64'd0, 64'd0);
    @(negedge clk);
    drive_req(MEM_WR, 64'h48, 64'hABCD, 64'd0);
    n = 0;
    while (!rsp_val && n < 20) begin
      @(negedge clk);
      n++;
    end
    held = rsp_data;
    chk("t4_rsp_data", held, 64'd9);
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_val", 64'(rsp_val), 64'd1);
      chk("t4_stall_data", rsp_data, held);
      chk("t4_stall_rdy", 64'(req_rdy), 64'd0);
      @(negedge clk);
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    chk("t4_after_hs_rdy", 64'(req_rdy), 64'd1);
    chk("t4_after_hs_val", 64'(rsp_val), 64'd0);
    @(negedge clk);
    chk("t4_accepted", 64'(req_rdy), 64'd0);
    req_val = 1'b0;
    r = ref_apply(MEM_WR, 64'h48, 64'hABCD, 64'd0);
    lat = 1;
    while (!rsp_val && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("t4_wr_latency", 64'(lat), 64'd2);
    chk("t4_wr_rsp", rsp_data, 64'd0);
    do_req(MEM_RD, 64'h48, 64'd0, 64'd0, r);
    chk("t4_rd_back", r, 64'hABCD);

    // 5: out-of-range read and misaligned write
    chk("t5_err_before", 64'(err), 64'd0);
    w0 = en_cnt;
    do_req(MEM_RD, 64'(MEM_WORDS * 8), 64'd0, 64'd0, r);
    chk("t5_range_rsp", r, 64'd0);
    do_req(MEM_WR, 64'h43, 64'h1234, 64'd0, r);
    chk("t5_align_rsp", r, 64'd0);
    chk("t5_err", 64'(err), 64'd1);
    chk("t5_no_en", 64'(en_cnt - w0), 64'd0);
    do_req(MEM_RD, 64'h40, 64'd0, 64'd0, r);
    chk("t5_mem_intact", r, 64'd9);

    // 6: reset in the CMP cycle of a matching CAS
    @(negedge clk);
    drive_req(MEM_CAS, 64'h40, 64'h77, 64'd9);
    @(negedge clk);
    req_val = 1'b0;
    @(negedge clk);
    chk("t6_cmp_writing", 64'({sram_en, sram_we}), 64'd3);
    w0 = wr_cnt;
    rst = 1'b1;
    #1;
    chk("t6_rst_req_rdy", 64'(req_rdy), 64'd1);
    chk("t6_rst_rsp_val", 64'(rsp_val), 64'd0);
    chk("t6_rst_rsp_data", rsp_data, 64'd0);
    chk("t6_rst_sram_en", 64'(sram_en), 64'd0);
    chk("t6_rst_err", 64'(err), 64'd0);
    chk("t6_rst_cnt", 64'(cas_fail_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ref_err = 1'b0;
    ref_cnt = '0;
    chk("t6_no_write", 64'(wr_cnt - w0), 64'd0);
    do_req(MEM_RD, 64'h40, 64'd0, 64'd0, r);
    chk("t6_rd_after", r, 64'd9);

    // Randomized traffic over a small window of words
    for (int i = 0; i < 16; i++)
      do_req(MEM_WR, 64'(i * 8), {$urandom, $urandom}, 64'd0, r);
    for (int i = 0; i < 60; i++) begin
      mem_op_e op;
      logic [DATA_W-1:0] a, d, e;
      int word;
      op   = mem_op_e'(2'($urandom_range(0, 2)));
      word = int'($urandom_range(0, 15));
      a    = 64'(word * 8);
      if ($urandom_range(0, 9) == 0) a = a + 64'($urandom_range(1, 7));
      if ($urandom_range(0, 19) == 0) a = 64'(MEM_WORDS * 8) + a;
      d = {$urandom, $urandom};
      e = ($urandom_range(0, 1) == 1) ? ref_mem[word] : {$urandom, $urandom};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(op, a, d, e, r);
    end
    chk("rand_err", 64'(err), 64'(ref_err));
    chk("rand_cnt", 64'(cas_fail_cnt), 64'(ref_cnt));
    chk("sram_idle_zero", 64'(idle_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/falafel_mem_bridge.md
Name: falafel_mem_bridge

Overview:
- Memory-side stage directly downstream of the falafel wrapper's memory request/response ports.
- Accepts one read, write or compare-and-swap (CAS) request at a time and executes it against a single-port synchronous SRAM with 1-cycle read latency.
- Returns exactly one response per request; CAS is atomic because only one request is ever outstanding.
- Used as the backing heap memory for allocator simulation and FPGA bring-up.

Parameters:
MEM_WORDS, 1024, SRAM depth in DATA_W-bit words; must be a power of two.
ADDR_W, $clog2(MEM_WORDS), localparam; SRAM word-address width.
BYTE_OFF, $clog2(DATA_W/8), localparam; byte-to-word shift.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
mem_req_val_i  in  1  request valid
mem_req_rdy_o  out  1  bridge ready
mem_req_is_write_i  in  1  1 = write/CAS, 0 = read
mem_req_is_cas_i  in  1  1 = CAS (only meaningful with is_write)
mem_req_addr_i  in  DATA_W  byte address
mem_req_data_i  in  DATA_W  write data / CAS new value
mem_req_cas_exp_i  in  DATA_W  CAS expected value
mem_rsp_val_o  out  1  response valid
mem_rsp_rdy_i  in  1  falafel ready
mem_rsp_data_o  out  DATA_W  response data
sram_en_o  out  1  SRAM access enable
sram_we_o  out  1  SRAM write enable
sram_addr_o  out  ADDR_W  SRAM word address
sram_wdata_o  out  DATA_W  SRAM write data
sram_rdata_i  in  DATA_W  SRAM read data, valid the cycle after a read enable
err_o  out  1  sticky: an out-of-range or misaligned address was seen
cas_fail_cnt_o  out  16  saturating count of failed CAS operations

Behaviour:
- Reset (async, rst_i=1):
  - state = IDLE; all request/response registers cleared.
  - mem_req_rdy_o=1, mem_rsp_val_o=0, mem_rsp_data_o=0.
  - sram_en_o=0, sram_we_o=0, err_o=0, cas_fail_cnt_o=0.
  - Reset mid-operation abandons the request. No SRAM write occurs after reset asserts.
- Handshakes:
  - A request is accepted on mem_req_val_i && mem_req_rdy_o.
  - mem_req_rdy_o=1 only in IDLE.
  - A response completes on mem_rsp_val_o && mem_rsp_rdy_i. While stalled, mem_rsp_val_o and mem_rsp_data_o stay stable.
- Accept: latch opcode, word address (addr >> BYTE_OFF, low ADDR_W bits), data and exp.
  - Range error: addr >> BYTE_OFF >= MEM_WORDS.
  - Alignment error: addr[BYTE_OFF-1:0] != 0.
  - Either error: set err_o and mark the request bad.
- FSM states: IDLE, RD, WR, CMP, RSP.
  - IDLE -> RD: accept of a read or CAS.
  - IDLE -> WR: accept of a plain write.
  - RD: sram_en=1, we=0 -> CMP.
  - WR: sram_en=1, we=1, wdata=data; response data=0 -> RSP.
  - CMP: capture sram_rdata_i into the response register.
    - CAS with rdata==exp: sram_en=1, we=1, wdata=data in the same cycle.
    - CAS with mismatch: no write; cas_fail_cnt increments, saturating at 16'hFFFF.
    - Then -> RSP.
  - RSP: mem_rsp_val_o=1; on handshake -> IDLE, so ready returns the following cycle.
- Bad request: no SRAM enable in any state. The FSM still walks its path; the response is 0. CAS fail count is unaffected.
- Response data:
  - read: word read.
  - write: 0.
  - CAS: old memory value. The core detects success as rsp == exp.
- Latency, accept cycle T to mem_rsp_val_o:
  - read T+3, CAS T+3, write T+2.
  - Peak throughput: one request per 4 cycles (read) with rdy_i held high.
- sram_* outputs are 0 whenever sram_en_o=0.

Decomposition:
- falafel_pkg gains a mem_op_e enum (MEM_RD, MEM_WR, MEM_CAS) and a mem_req_t struct (op, addr, data, exp). Both are reused by future cache/arbiter stages.
- No sub-module in the RTL. The bench provides a behavioural falafel_sram model (1-cycle read, write-first irrelevant since single port).

Test Plan:
1. Write addr 0x40 data 0xDEAD_BEEF, then read 0x40. Required: write response 0 at T+2; read response 0xDEAD_BEEF at T+3; sram_addr_o=8 for DATA_W=64.
2. Preload word 8 = 5, CAS addr 0x40 exp=5 new=9. Required: response 5; subsequent read returns 9; cas_fail_cnt_o stays 0.
3. Same CAS with exp=7 while memory=9. Required: response 9; memory stays 9; cas_fail_cnt_o=1.
4. Hold mem_rsp_rdy_i=0 for 5 cycles after a read. Required: mem_rsp_val_o and mem_rsp_data_o stable; mem_req_rdy_o=0 throughout; a new valid request is not accepted until 1 cycle after the handshake.
5. Read addr MEM_WORDS*8, then write addr 0x43. Required: err_o=1; responses 0; sram_en_o never asserted; FSM returns to IDLE.
6. Assert rst_i during CMP of a CAS that would match. Required: no SRAM write; all outputs at reset values immediately; next request is processed normally.
